// File: rtl/mdu_issue_ctrl_pkg.sv
// rtl/mdu_issue_ctrl_pkg.sv - MDU opcode encoding, FSM states and classification helpers
package mdu_issue_ctrl_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        MSUB  = 4'd3,
        DIV   = 4'd4,
        DIVU  = 4'd5,
        MTHI  = 4'd6,
        MTLO  = 4'd7,
        MFHI  = 4'd8,
        MFLO  = 4'd9
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int unsigned DEF_MUL_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES = 10;

    function automatic logic is_long(input logic [3:0] op);
        case (op)
            MULT, MULTU, MSUB, DIV, DIVU: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == MTHI) || (op == MTLO);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// rtl/mdu_issue_ctrl_if.sv - pipeline/datapath signal bundle around the MDU issue controller
interface mdu_issue_ctrl_if;
    logic       e_valid;
    logic [3:0] e_op;
    logic       d_is_mdu;
    logic       int_exc_req;
    logic       dp_start;
    logic [3:0] dp_op;
    logic       dp_wr_hilo;
    logic       dp_commit;
    logic       busy;
    logic       stall;
    logic       proto_err;

    // master is the controller; slave is the pipeline/datapath side
    modport master (
        input  e_valid, e_op, d_is_mdu, int_exc_req,
        output dp_start, dp_op, dp_wr_hilo, dp_commit, busy, stall, proto_err
    );

    modport slave (
        output e_valid, e_op, d_is_mdu, int_exc_req,
        input  dp_start, dp_op, dp_wr_hilo, dp_commit, busy, stall, proto_err
    );
endinterface

// File: rtl/mdu_lat_counter.sv
// rtl/mdu_lat_counter.sv - loadable down-counter with zero flag for MDU operation latency
module mdu_lat_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;

    // saturates at zero so a late decrement cannot wrap into a bogus long wait
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - issue, latency tracking, stall and HI/LO commit for the MDU
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    mdu_issue_ctrl_if.master bus
);

    localparam int unsigned   CW       = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    mdu_state_e    state_q;
    logic          busy_q;
    logic          commit_q;
    logic          proto_err_q;
    logic          is_idle;
    logic          issue;
    logic [CW-1:0] load_val;
    logic [CW-1:0] cnt;
    logic          cnt_zero;

    assign is_idle  = (state_q == ST_IDLE);
    assign issue    = is_idle & bus.e_valid & is_long(bus.e_op) & ~bus.int_exc_req;
    assign load_val = is_div(bus.e_op) ? DIV_LOAD : MUL_LOAD;

    mdu_lat_counter #(.CW(CW)) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (issue),
        .load_val_i (load_val),
        .dec_i      (state_q == ST_RUN),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // commit_q is computed one cycle early so it lands exactly when RUN sees cnt==0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            commit_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    commit_q <= 1'b0;
                    if (issue) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        commit_q <= (load_val == '0);
                    end
                end
                ST_RUN: begin
                    if (cnt_zero) begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        commit_q <= 1'b0;
                    end else begin
                        commit_q <= (cnt == CW'(1));
                    end
                    // an interrupt in RUN is deliberately not looked at here
                    if (bus.e_valid && (is_long(bus.e_op) || is_mt(bus.e_op))) begin
                        proto_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    commit_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dp_start   = issue;
    assign bus.dp_op      = bus.e_op;
    assign bus.dp_wr_hilo = is_idle & bus.e_valid & is_mt(bus.e_op) & ~bus.int_exc_req;
    assign bus.dp_commit  = commit_q;
    assign bus.busy       = busy_q;
    assign bus.stall      = bus.d_is_mdu & (issue | busy_q);
    assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb/tb_mdu_issue_ctrl.sv - directed vector table plus multi-cycle sequences for mdu_issue_ctrl
module tb_mdu_issue_ctrl;
    import mdu_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mdu_issue_ctrl_if bus();

    mdu_issue_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic       dmdu;
        logic       exc;
        logic       x_start;
        logic       x_wr;
        logic       x_stall;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.e_valid     = 1'b0;
        bus.e_op        = NONE;
        bus.int_exc_req = 1'b0;
    endtask

    // Issue op now, then check cycles 1..lat of the run and the first cycle after it.
    task automatic issue_and_track(input logic [3:0] op, input int lat,
                                   input int exc_at, input int viol_at);
        bus.e_valid     = 1'b1;
        bus.e_op        = op;
        bus.int_exc_req = 1'b0;
        bus.d_is_mdu    = 1'b1;
        @(negedge clk);
        chk("issue_start", bus.dp_start, 1);
        chk("issue_op", bus.dp_op, op);
        chk("issue_busy", bus.busy, 0);
        chk("issue_stall", bus.stall, 1);
        step();
        idle_inputs();
        for (int k = 1; k <= lat; k++) begin
            bus.int_exc_req = (k == exc_at);
            if (k == viol_at) begin
                bus.e_valid = 1'b1;
                bus.e_op    = MULT;
            end
            @(negedge clk);
            chk("run_busy", bus.busy, 1);
            chk("run_commit", bus.dp_commit, (k == lat));
            chk("run_stall", bus.stall, 1);
            chk("run_no_start", bus.dp_start, 0);
            chk("run_proto", bus.proto_err, (viol_at > 0 && k > viol_at));
            step();
            idle_inputs();
        end
        @(negedge clk);
        chk("post_busy", bus.busy, 0);
        chk("post_commit", bus.dp_commit, 0);
        chk("post_stall", bus.stall, 0);
        chk("post_proto", bus.proto_err, (viol_at > 0));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, MULT,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, MULTU, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, MSUB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, DIV,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, MTHI,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, MTLO,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, MFHI,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, MFLO,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, NONE,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'hF,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, MULT,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, MULT,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, MTLO,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, DIVU,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        idle_inputs();
        bus.d_is_mdu = 1'b0;
        reset = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_commit", bus.dp_commit, 0);
        chk("rst_proto", bus.proto_err, 0);
        chk("rst_stall", bus.stall, 0);
        step();
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            bus.e_valid     = vecs[i].v;
            bus.e_op        = vecs[i].op;
            bus.d_is_mdu    = vecs[i].dmdu;
            bus.int_exc_req = vecs[i].exc;
            @(negedge clk);
            chk("vec_start", bus.dp_start, vecs[i].x_start);
            chk("vec_wr_hilo", bus.dp_wr_hilo, vecs[i].x_wr);
            chk("vec_stall", bus.stall, vecs[i].x_stall);
            chk("vec_commit", bus.dp_commit, 0);
            step();
            idle_inputs();
            bus.d_is_mdu = 1'b0;
            chk("vec_busy_next", bus.busy, vecs[i].x_start);
            for (int c = 0; c < 40 && bus.busy; c++) step();
            chk("vec_back_idle", bus.busy, 0);
            step();
        end

        // MULT: busy for 5 cycles, commit in the 5th
        issue_and_track(MULT, 5, 0, 0);
        // DIVU: stall held through start and all 10 busy cycles
        issue_and_track(DIVU, 10, 0, 0);
        // interrupt during RUN must not move the commit
        issue_and_track(DIV, 10, 4, 0);

        // reset two cycles after issue kills the op with no commit
        bus.e_valid  = 1'b1;
        bus.e_op     = MULT;
        bus.d_is_mdu = 1'b1;
        @(negedge clk);
        chk("rm_start", bus.dp_start, 1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("rm_busy_t1", bus.busy, 1);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rm_commit_t2", bus.dp_commit, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rm_busy_t3", bus.busy, 0);
        chk("rm_commit_t3", bus.dp_commit, 0);
        step();
        issue_and_track(MULT, 5, 0, 0);

        // protocol violation mid-run: sticky flag, original op unaffected
        issue_and_track(MULT, 5, 0, 2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("proto_sticky", bus.proto_err, 1);
            chk("proto_no_commit", bus.dp_commit, 0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("proto_cleared", bus.proto_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
